dm_lsu: RTL

- Load/store unit that consumes the control decoder's memory-side outputs: MemWrite, DMType, plus a load strobe.
- Executes each access against a word-wide data memory with a req/ack handshake and no byte enables. Sub-word stores use read-modify-write.
- Sign- or zero-extends load data and stalls the core until the access completes.
- Sits between the datapath (ALU address, rs2 data, WDSel memory path) and the data memory.

---
 rtl/dm_lsu_pkg.sv | 21 ++
 rtl/dm_lsu_if.sv | 20 ++
 rtl/dm_lsu_lane.sv | 33 +++
 rtl/dm_lsu.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dm_lsu_pkg.sv
// Shared encodings for the load/store unit: DMType codes,
// LSU state encodings and the default memory timeout.
package ctrl_encode_def;

    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_RD,
        LSU_RMW_RD,
        LSU_WR,
        LSU_DONE
    } lsu_state_t;

    localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/dm_lsu_if.sv
// Word-wide data memory bus with req/ack handshake.
// master = load/store unit, slave = memory.
interface dm_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dm_lsu_lane.sv
// Byte/half lane logic: extends a loaded lane and merges
// store data into a read word at the addressed lane.
module dm_lane
    import ctrl_encode_def::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  dmtype,
    input  logic [31:0] wdata,
    output logic [31:0] ext,
    output logic [31:0] merged
);
    logic [7:0]  b;
    logic [15:0] h;

    // Lane select, extension and sub-word merge
    always_comb begin
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        unique case (dmtype)
            dm_halfword:          ext = {{16{h[15]}}, h};
            dm_halfword_unsigned: ext = {16'b0, h};
            dm_byte:              ext = {{24{b[7]}}, b};
            dm_byte_unsigned:     ext = {24'b0, b};
            default:              ext = word;
        endcase
        merged = word;
        if (dmtype == dm_byte)
            merged[{off, 3'b000} +: 8] = wdata[7:0];
        else if (dmtype == dm_halfword)
            merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
    end
endmodule

// File: rtl/dm_lsu.sv
// Load/store unit: runs one access per request against a
// word memory, read-modify-write for sub-word stores.
module dm_lsu
    import ctrl_encode_def::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  DMType,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    dm_lsu_if.master    mem
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    lsu_state_t    state;
    logic [CW-1:0] cnt;
    logic [1:0]    a_off;
    logic [2:0]    a_type;
    logic [31:0]   a_wdata;
    logic          illegal;
    logic          wait_last;
    logic [31:0]   lane_ext;
    logic [31:0]   lane_merged;

    dm_lane u_lane (
        .word   (mem.mem_rdata),
        .off    (a_off),
        .dmtype (a_type),
        .wdata  (a_wdata),
        .ext    (lane_ext),
        .merged (lane_merged)
    );

    assign stall = (MemRead | MemWrite) && (state != LSU_DONE);
    assign wait_last = (cnt == CW'(TIMEOUT_CYC - 1));

    // Request legality from the live decoder outputs
    always_comb begin
        illegal = (DMType > dm_byte_unsigned)
            || ((DMType == dm_halfword
                 || DMType == dm_halfword_unsigned) && addr[0])
            || ((DMType == dm_word) && (addr[1:0] != 2'b00))
            || (MemWrite && (DMType == dm_halfword_unsigned
                 || DMType == dm_byte_unsigned));
    end

    // Access sequencer with registered bus and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LSU_IDLE;
            cnt           <= '0;
            a_off         <= 2'b00;
            a_type        <= 3'b000;
            a_wdata       <= 32'h0;
            rdata         <= 32'h0;
            done          <= 1'b0;
            fault         <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'h0;
            mem.mem_wdata <= 32'h0;
        end else begin
            done <= 1'b0;
            unique case (state)
                LSU_IDLE: begin
                    if (MemRead | MemWrite) begin
                        a_off   <= addr[1:0];
                        a_type  <= DMType;
                        a_wdata <= wdata;
                        cnt     <= '0;
                        if (illegal) begin
                            state <= LSU_DONE;
                            done  <= 1'b1;
                            fault <= 1'b1;
                            rdata <= 32'h0;
                        end else begin
                            mem.mem_req  <= 1'b1;
                            mem.mem_addr <= {addr[31:2], 2'b00};
                            if (!MemWrite) begin
                                state      <= LSU_RD;
                                mem.mem_we <= 1'b0;
                            end else if (DMType == dm_word) begin
                                state         <= LSU_WR;
                                mem.mem_we    <= 1'b1;
                                mem.mem_wdata <= wdata;
                            end else begin
                                state      <= LSU_RMW_RD;
                                mem.mem_we <= 1'b0;
                            end
                        end
                    end
                end
                LSU_RD, LSU_RMW_RD, LSU_WR: begin
                    if (mem.mem_ack) begin
                        cnt <= '0;
                        if (state == LSU_RMW_RD) begin
                            state         <= LSU_WR;
                            mem.mem_we    <= 1'b1;
                            mem.mem_wdata <= lane_merged;
                        end else begin
                            state       <= LSU_DONE;
                            done        <= 1'b1;
                            fault       <= 1'b0;
                            mem.mem_req <= 1'b0;
                            mem.mem_we  <= 1'b0;
                            if (state == LSU_RD)
                                rdata <= lane_ext;
                        end
                    end else if (wait_last) begin
                        state       <= LSU_DONE;
                        done        <= 1'b1;
                        fault       <= 1'b1;
                        rdata       <= 32'h0;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LSU_DONE: state <= LSU_IDLE;
                default:  state <= LSU_IDLE;
            endcase
        end
    end
endmodule
